// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point FFT sweep controller.
package fft8_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam int N_BINS = 8;
    localparam int IDX_W  = 3;

    function automatic logic [IDX_W-1:0] bitrev3(input logic [IDX_W-1:0] i);
        return {i[0], i[1], i[2]};
    endfunction

endpackage

// File: rtl/fft8_bin_buf.sv
// 8-entry complex bin store: one write port for the sweep, one registered read port
// for the stream. Only the read register is reset; the array itself is not.
module fft8_bin_buf
    import fft8_pkg::*;
#(
    parameter int W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic signed [W-1:0] wr_re,
    input  logic signed [W-1:0] wr_im,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic signed [W-1:0] rd_re,
    output logic signed [W-1:0] rd_im
);

    logic signed [W-1:0] mem_re_q [N_BINS];
    logic signed [W-1:0] mem_im_q [N_BINS];
    logic signed [W-1:0] rd_re_d, rd_re_q;
    logic signed [W-1:0] rd_im_d, rd_im_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_re_q[wr_addr] <= wr_re;
            mem_im_q[wr_addr] <= wr_im;
        end
    end

    // Read register holds its value whenever rd_en is low (stream stall).
    always_comb begin
        rd_re_d = rd_re_q;
        rd_im_d = rd_im_q;
        if (rd_en) begin
            rd_re_d = mem_re_q[rd_addr];
            rd_im_d = mem_im_q[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_re_q <= '0;
            rd_im_q <= '0;
        end else begin
            rd_re_q <= rd_re_d;
            rd_im_q <= rd_im_d;
        end
    end

    assign rd_re = rd_re_q;
    assign rd_im = rd_im_q;

endmodule

// File: rtl/fft8_sweep_ctrl.sv
// Sweeps the FFT core's bin select, captures all 8 bins, then streams them out.
// Optional macro BITREV_ORDER_EN streams bins in bit-reversed order.
module fft8_sweep_ctrl
    import fft8_pkg::*;
#(
    parameter int W          = 9,
    parameter int SETTLE_CYC = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [IDX_W-1:0]    fft_sel,
    input  logic signed [W-1:0] fft_yr,
    input  logic signed [W-1:0] fft_yi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC);

    state_t           state_d, state_q;
    logic [IDX_W-1:0] sel_d, sel_q;
    logic [IDX_W-1:0] swp_idx_d, swp_idx_q;
    logic [3:0]       settle_d, settle_q;
    logic [IDX_W-1:0] rd_d, rd_q;
    logic             valid_d, valid_q;
    logic [IDX_W-1:0] oidx_d, oidx_q;
    logic             last_d, last_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic             wr_en, rd_en;
    logic [IDX_W-1:0] rd_addr, rd_nxt;

    function automatic logic [IDX_W-1:0] stream_bin(input logic [IDX_W-1:0] r);
`ifdef BITREV_ORDER_EN
        return bitrev3(r);
`else
        return r;
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        swp_idx_d = swp_idx_q;
        settle_d  = settle_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        oidx_d    = oidx_q;
        last_d    = last_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_nxt    = rd_q + 3'd1;
        rd_addr   = stream_bin(rd_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SWEEP;
                    swp_idx_d = '0;
                    sel_d     = '0;
                    settle_d  = '0;
                end
            end
            SWEEP: begin
                if (settle_q == SETTLE_LAST) begin
                    wr_en    = 1'b1;
                    settle_d = '0;
                    if (swp_idx_q == 3'(N_BINS - 1)) begin
                        state_d = STREAM;
                    end else begin
                        swp_idx_d = swp_idx_q + 3'd1;
                        sel_d     = swp_idx_q + 3'd1;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            STREAM: begin
                // First STREAM cycle only loads the read register; no handshake yet.
                if (!valid_q) begin
                    rd_en   = 1'b1;
                    rd_d    = '0;
                    rd_addr = stream_bin(3'd0);
                    oidx_d  = stream_bin(3'd0);
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                end else if (out_ready) begin
                    if (rd_q == 3'(N_BINS - 1)) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        rd_en   = 1'b1;
                        rd_d    = rd_nxt;
                        rd_addr = stream_bin(rd_nxt);
                        oidx_d  = stream_bin(rd_nxt);
                        last_d  = (rd_nxt == 3'(N_BINS - 1));
                    end
                end
            end
            FIN: begin
                state_d   = IDLE;
                sel_d     = '0;
                swp_idx_d = '0;
                rd_d      = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            swp_idx_q <= '0;
            settle_q  <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            oidx_q    <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            swp_idx_q <= swp_idx_d;
            settle_q  <= settle_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            oidx_q    <= oidx_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    fft8_bin_buf #(.W(W)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (swp_idx_q),
        .wr_re   (fft_yr),
        .wr_im   (fft_yi),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_re   (out_re),
        .rd_im   (out_im)
    );

    assign fft_sel   = sel_q;
    assign out_valid = valid_q;
    assign out_idx   = oidx_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fft8_sweep_ctrl.sv
// Directed bench for fft8_sweep_ctrl with a behavioural FFT core model (yr=10*sel+1, yi=-(sel+1)).
module tb_fft8_sweep_ctrl;

    localparam int W = 9;

    typedef struct {
        int idx;
        int re;
        int im;
        int last;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic out_ready = 1'b1;

    logic [2:0]          sel_a, sel_b, idx_a, idx_b;
    logic signed [W-1:0] yr_a, yi_a, yr_b, yi_b;
    logic signed [W-1:0] re_a, im_a, re_b, im_b;
    logic                valid_a, valid_b, last_a, last_b, busy_a, busy_b, done_a, done_b;

    always #5 clk = ~clk;

    assign yr_a = W'(10 * int'(sel_a) + 1);
    assign yi_a = W'(-(int'(sel_a) + 1));
    assign yr_b = W'(10 * int'(sel_b) + 1);
    assign yi_b = W'(-(int'(sel_b) + 1));

    fft8_sweep_ctrl #(.W(W), .SETTLE_CYC(1)) dut (
        .clk(clk), .rst(rst), .start(start_a), .fft_sel(sel_a),
        .fft_yr(yr_a), .fft_yi(yi_a), .out_valid(valid_a), .out_ready(out_ready),
        .out_re(re_a), .out_im(im_a), .out_idx(idx_a), .out_last(last_a),
        .busy(busy_a), .done(done_a)
    );

    fft8_sweep_ctrl #(.W(W), .SETTLE_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_b), .fft_sel(sel_b),
        .fft_yr(yr_b), .fft_yi(yi_b), .out_valid(valid_b), .out_ready(out_ready),
        .out_re(re_b), .out_im(im_b), .out_idx(idx_b), .out_last(last_b),
        .busy(busy_b), .done(done_b)
    );

    // View of whichever instance is under test
    logic                use_b = 1'b0;
    logic [2:0]          m_sel, m_idx;
    logic signed [W-1:0] m_re, m_im;
    logic                m_valid, m_last, m_busy, m_done;
    assign m_sel   = use_b ? sel_b   : sel_a;
    assign m_idx   = use_b ? idx_b   : idx_a;
    assign m_re    = use_b ? re_b    : re_a;
    assign m_im    = use_b ? im_b    : im_a;
    assign m_valid = use_b ? valid_b : valid_a;
    assign m_last  = use_b ? last_b  : last_a;
    assign m_busy  = use_b ? busy_b  : busy_a;
    assign m_done  = use_b ? done_b  : done_a;

    int    n_tests = 0;
    int    n_fail  = 0;
    xfer_t exp_tbl [8];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (use_b) start_b = v;
        else       start_a = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " sel"},   int'(m_sel),   0);
        chk({tag, " valid"}, int'(m_valid), 0);
        chk({tag, " re"},    int'(m_re),    0);
        chk({tag, " im"},    int'(m_im),    0);
        chk({tag, " idx"},   int'(m_idx),   0);
        chk({tag, " last"},  int'(m_last),  0);
        chk({tag, " busy"},  int'(m_busy),  0);
        chk({tag, " done"},  int'(m_done),  0);
    endtask

    // One full sweep+stream; bp selects the 1,0,0,1 ready pattern, restart re-pulses start.
    task automatic run_sweep(input string tag, input int settle, input bit bp, input bit restart);
        int  n, xfer, first_v, last_hs, done_cnt, done_n, vcnt, sweep_len;
        bit  pv, pr;
        int  p_re, p_im, p_idx, p_last;
        bit  rdy;
        bit  pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        n = 0; xfer = 0; first_v = -1; last_hs = -1; done_cnt = 0; done_n = -1; vcnt = 0;
        pv = 0; pr = 0; p_re = 0; p_im = 0; p_idx = 0; p_last = 0;
        sweep_len = 8 * (settle + 1);
        out_ready = 1'b1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        chk({tag, " busy after start"}, int'(m_busy), 1);
        while (n < 300 && !(done_n >= 0 && n > done_n + 2)) begin
            set_start(1'b0);
            if (n < sweep_len)
                chk({tag, " sel step"}, int'(m_sel), n / (settle + 1));
            if (restart && (n == 5 || (first_v >= 0 && n == first_v + 2)))
                set_start(1'b1);
            if (m_done) begin
                done_cnt++;
                done_n = n;
            end
            if (m_valid) begin
                if (first_v < 0) begin
                    first_v = n;
                    chk({tag, " first valid latency"}, n, sweep_len + 1);
                end
                if (pv && !pr) begin
                    chk({tag, " stall re"},   int'(m_re),   p_re);
                    chk({tag, " stall im"},   int'(m_im),   p_im);
                    chk({tag, " stall idx"},  int'(m_idx),  p_idx);
                    chk({tag, " stall last"}, int'(m_last), p_last);
                end
                rdy = bp ? pat[vcnt % 4] : 1'b1;
                vcnt++;
                out_ready = rdy;
                if (rdy) begin
                    if (xfer < 8) begin
                        chk({tag, " bin idx"},  int'(m_idx),  exp_tbl[xfer].idx);
                        chk({tag, " bin re"},   int'(m_re),   exp_tbl[xfer].re);
                        chk({tag, " bin im"},   int'(m_im),   exp_tbl[xfer].im);
                        chk({tag, " bin last"}, int'(m_last), exp_tbl[xfer].last);
                    end
                    xfer++;
                    last_hs = n;
                end
                pv = 1'b1; pr = rdy;
                p_re = int'(m_re); p_im = int'(m_im); p_idx = int'(m_idx); p_last = int'(m_last);
            end else begin
                pv = 1'b0;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        set_start(1'b0);
        out_ready = 1'b1;
        chk({tag, " finished in budget"}, int'(n < 300), 1);
        chk({tag, " transfers"}, xfer, 8);
        chk({tag, " done count"}, done_cnt, 1);
        chk({tag, " done after last hs"}, done_n, last_hs + 1);
        chk({tag, " idle busy"}, int'(m_busy), 0);
        chk({tag, " idle sel"}, int'(m_sel), 0);
        chk({tag, " idle valid"}, int'(m_valid), 0);
    endtask

    initial begin
        int b;
        logic [2:0] k3;
        for (int k = 0; k < 8; k++) begin
            k3 = 3'(k);
`ifdef BITREV_ORDER_EN
            b = int'({k3[0], k3[1], k3[2]});
`else
            b = int'(k3);
`endif
            exp_tbl[k].idx  = b;
            exp_tbl[k].re   = 10 * b + 1;
            exp_tbl[k].im   = -(b + 1);
            exp_tbl[k].last = (k == 7) ? 1 : 0;
        end

        #12;
        check_reset_outputs("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_sweep("basic", 1, 1'b0, 1'b0);
        run_sweep("backpressure", 1, 1'b1, 1'b0);
        run_sweep("start busy", 1, 1'b0, 1'b1);

        // Reset asserted mid-sweep at bin 3, checked asynchronously before the next edge
        begin
            int guard;
            guard = 0;
            set_start(1'b1);
            @(posedge clk); #1;
            set_start(1'b0);
            while (m_sel != 3'd3 && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            chk("midreset reached sel3", int'(m_sel), 3);
            #1 rst = 1'b1;
            #1;
            check_reset_outputs("midreset");
            @(negedge clk); rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                chk("midreset no done", int'(m_done), 0);
                chk("midreset stays idle", int'(m_busy), 0);
            end
        end
        run_sweep("after reset", 1, 1'b0, 1'b0);

        use_b = 1'b1;
        @(posedge clk); #1;
        run_sweep("settle0", 0, 1'b0, 1'b0);
        run_sweep("settle0 bp", 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
